// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: handshake, data and status bundle of the single-clock FIFO.
// master = producer/consumer side (drives requests), slave = the FIFO itself.
interface sync_fifo_ctrl_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);
   logic                  w_en;
   logic [DATASIZE-1:0]   wdata;
   logic                  r_en;
   logic [DATASIZE-1:0]   rdata;
   logic                  rvalid;
   logic                  wfull;
   logic                  rempty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDRSIZE:0]     count;
   logic                  overflow;
   logic                  underflow;
   logic                  par_err;

   modport master (
      output w_en, wdata, r_en,
      input  rdata, rvalid, wfull, rempty, almost_full, almost_empty,
             count, overflow, underflow, par_err
   );

   modport slave (
      input  w_en, wdata, r_en,
      output rdata, rvalid, wfull, rempty, almost_full, almost_empty,
             count, overflow, underflow, par_err
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with a registered read port, full/empty
// and programmable almost-full/almost-empty flags, occupancy count and sticky
// overflow/underflow flags. All flags are registers updated from the next
// pointer values, so no request input reaches a flag combinationally.
// Optional feature macro: SYNC_FIFO_PARITY_EN -- stores an even-parity bit per
// word and pulses par_err alongside rvalid when a read word fails the check.
module sync_fifo_ctrl #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic            wclk,
   input  logic            wrst_n,
   sync_fifo_ctrl_if.slave bus
);
   localparam int DEPTH = int'(32'd1 << ADDRSIZE);
   localparam int PW    = ADDRSIZE + 32'sd1;

`ifdef SYNC_FIFO_PARITY_EN
   localparam int MW = DATASIZE + 32'sd1;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_par(input logic [DATASIZE-1:0] d);
      return ^d;
   endfunction
`else
   localparam int MW = DATASIZE;
`endif

   localparam logic [PW-1:0] PTR_ONE   = {{ADDRSIZE{1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

   logic [MW-1:0]       mem_r [DEPTH];
   logic [PW-1:0]       wptr_r;
   logic [PW-1:0]       rptr_r;
   logic [PW-1:0]       count_r;
   logic                wfull_r;
   logic                rempty_r;
   logic                afull_r;
   logic                aempty_r;
   logic [DATASIZE-1:0] rdata_r;
   logic                rvalid_r;
   logic                ovf_r;
   logic                unf_r;
   logic                perr_r;

   logic                wr_acc_s;
   logic                rd_acc_s;
   logic [PW-1:0]       wptr_nxt_s;
   logic [PW-1:0]       rptr_nxt_s;
   logic [PW-1:0]       count_nxt_s;
   logic [MW-1:0]       wr_word_s;
   logic [MW-1:0]       rd_word_s;
   logic                perr_nxt_s;

   // Accept decisions use only the registered flags; next pointers and occupancy follow from them.
   always_comb begin
      wr_acc_s = bus.w_en & ~wfull_r;
      rd_acc_s = bus.r_en & ~rempty_r;
      if (wr_acc_s) begin
         wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
         wptr_nxt_s = wptr_r;
      end
      if (rd_acc_s) begin
         rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
         rptr_nxt_s = rptr_r;
      end
      // Modulo 2*DEPTH subtraction handles the wrap bit naturally.
      count_nxt_s = wptr_nxt_s - rptr_nxt_s;
   end

   // Stored word format and read-side parity check.
   always_comb begin
`ifdef SYNC_FIFO_PARITY_EN
      wr_word_s = {even_par(bus.wdata), bus.wdata};
`else
      wr_word_s = bus.wdata;
`endif
      rd_word_s = mem_r[rptr_r[ADDRSIZE-1:0]];
      if (rd_acc_s) begin
`ifdef SYNC_FIFO_PARITY_EN
         perr_nxt_s = even_par(rd_word_s[DATASIZE-1:0]) ^ rd_word_s[DATASIZE];
`else
         perr_nxt_s = 1'b0;
`endif
      end else begin
         perr_nxt_s = 1'b0;
      end
   end

   // Storage array: written on accepted writes only, never reset.
   always_ff @(posedge wclk) begin
      if (wrst_n && wr_acc_s) begin
         mem_r[wptr_r[ADDRSIZE-1:0]] <= wr_word_s;
      end
   end

   // Pointers, registered flags, read port and sticky errors; reset wins over requests.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wptr_r   <= PTR_ZERO;
         rptr_r   <= PTR_ZERO;
         count_r  <= PTR_ZERO;
         wfull_r  <= 1'b0;
         rempty_r <= 1'b1;
         afull_r  <= 1'b0;
         aempty_r <= 1'b1;
         rdata_r  <= {DATASIZE{1'b0}};
         rvalid_r <= 1'b0;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
         perr_r   <= 1'b0;
      end else begin
         wptr_r   <= wptr_nxt_s;
         rptr_r   <= rptr_nxt_s;
         count_r  <= count_nxt_s;
         wfull_r  <= (count_nxt_s == DEPTH_CNT);
         rempty_r <= (count_nxt_s == PTR_ZERO);
         afull_r  <= (count_nxt_s >= AF_CNT);
         aempty_r <= (count_nxt_s <= AE_CNT);
         if (rd_acc_s) begin
            rdata_r <= rd_word_s[DATASIZE-1:0];
         end
         rvalid_r <= rd_acc_s;
         perr_r   <= perr_nxt_s;
         if (bus.w_en && wfull_r) begin
            ovf_r <= 1'b1;
         end
         if (bus.r_en && rempty_r) begin
            unf_r <= 1'b1;
         end
      end
   end

   assign bus.rdata        = rdata_r;
   assign bus.rvalid       = rvalid_r;
   assign bus.wfull        = wfull_r;
   assign bus.rempty       = rempty_r;
   assign bus.almost_full  = afull_r;
   assign bus.almost_empty = aempty_r;
   assign bus.count        = count_r;
   assign bus.overflow     = ovf_r;
   assign bus.underflow    = unf_r;
   assign bus.par_err      = perr_r;
endmodule
